// File: rtl/draw_sprite_pkg.sv
// Shared definitions for the sprite draw stage: VGA timing widths, the timing
// bundle carried down the pipeline and the default transparent key colour.
package draw_sprite_pkg;

  localparam int HCNT_W = 11;
  localparam int RGB_W  = 12;
  localparam int POS_W  = 12;

  localparam logic [RGB_W-1:0] TRANSPARENT_DEFAULT = 12'hF0F;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic              hsync;
    logic              hblnk;
    logic [HCNT_W-1:0] vcount;
    logic              vsync;
    logic              vblnk;
  } vga_timing_t;

  function automatic logic is_blank(input vga_timing_t t);
    return t.hblnk | t.vblnk;
  endfunction

endpackage

// File: rtl/draw_sprite_addr_gen.sv
// Combinational sprite box test and ROM address generation (scale, mirror,
// row*WIDTH+column). Arithmetic is done in 13 bits so the box never wraps.
module draw_sprite_addr_gen
  import draw_sprite_pkg::*;
#(
  parameter int WIDTH      = 328,
  parameter int HEIGHT     = 91,
  parameter int SCALE_LOG2 = 0,
  parameter int ADDR_W     = 15
) (
  input  logic [HCNT_W-1:0] hcount,
  input  logic [HCNT_W-1:0] vcount,
  input  logic [POS_W-1:0]  x,
  input  logic [POS_W-1:0]  y,
  input  logic              mirror,
  output logic              in_box,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [12:0] BOX_W = 13'(WIDTH << SCALE_LOG2);
  localparam logic [12:0] BOX_H = 13'(HEIGHT << SCALE_LOG2);

  logic [12:0]       h_s, v_s, x_s, y_s, dx_s, dy_s;
  logic [ADDR_W-1:0] rx_s, ry_s, col_s;

  assign h_s  = {2'b00, hcount};
  assign v_s  = {2'b00, vcount};
  assign x_s  = {1'b0, x};
  assign y_s  = {1'b0, y};
  assign dx_s = h_s - x_s;
  assign dy_s = v_s - y_s;

  assign in_box = (h_s >= x_s) && (h_s < x_s + BOX_W) &&
                  (v_s >= y_s) && (v_s < y_s + BOX_H);

  // Offsets are only meaningful inside the box; outside, addr is forced to 0.
  assign rx_s  = ADDR_W'(dx_s >> SCALE_LOG2);
  assign ry_s  = ADDR_W'(dy_s >> SCALE_LOG2);
  assign col_s = mirror ? (ADDR_W'(WIDTH - 1) - rx_s) : rx_s;
  assign addr  = in_box ? (ry_s * ADDR_W'(WIDTH) + col_s) : {ADDR_W{1'b0}};

endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: frame-synchronous latch of position/mode on the vblank
// rising edge, external sync ROM lookup and a fixed 2-cycle compositing pipeline.
module draw_sprite
  import draw_sprite_pkg::*;
#(
  parameter int                WIDTH       = 328,
  parameter int                HEIGHT      = 91,
  parameter int                SCALE_LOG2  = 0,
  parameter logic [RGB_W-1:0]  TRANSPARENT = TRANSPARENT_DEFAULT,
  parameter int                ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hcount_in,
  input  logic              hsync_in,
  input  logic              hblnk_in,
  input  logic [10:0]       vcount_in,
  input  logic              vsync_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic              enable,
  input  logic              mirror,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_pixel,
  output logic [10:0]       hcount_out,
  output logic              hsync_out,
  output logic              hblnk_out,
  output logic [10:0]       vcount_out,
  output logic              vsync_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out
);

  logic [11:0]       x_q, x_d, y_q, y_d;
  logic              en_q, en_d, mir_q, mir_d, vblnk_prev_q, vblnk_prev_d;
  vga_timing_t       s1_q, s1_d, s2_q, s2_d;
  logic [11:0]       rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic              hit1_q, hit1_d;
  logic              in_box_s;
  logic [ADDR_W-1:0] addr_s;

  draw_sprite_addr_gen #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .SCALE_LOG2 (SCALE_LOG2),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .hcount (hcount_in),
    .vcount (vcount_in),
    .x      (x_q),
    .y      (y_q),
    .mirror (mir_q),
    .in_box (in_box_s),
    .addr   (addr_s)
  );

  // The address is held at 0 while in reset so every output is quiet.
  assign rom_addr = reset ? addr_s : {ADDR_W{1'b0}};

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    en_d         = en_q;
    mir_d        = mir_q;
    vblnk_prev_d = vblnk_in;
    if (vblnk_in && !vblnk_prev_q) begin
      x_d   = xpos;
      y_d   = ypos;
      en_d  = enable;
      mir_d = mirror;
    end else begin
      x_d   = x_q;
      y_d   = y_q;
    end

    s1_d   = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
               vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};
    rgb1_d = rgb_in;
    hit1_d = in_box_s && en_q;

    // rom_pixel now carries the data for the address presented one cycle ago.
    s2_d = s1_q;
    if (is_blank(s1_q)) begin
      rgb2_d = 12'h000;
    end else if (hit1_q && (rom_pixel != TRANSPARENT)) begin
      rgb2_d = rom_pixel;
    end else begin
      rgb2_d = rgb1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q          <= 12'h000;
      y_q          <= 12'h000;
      en_q         <= 1'b0;
      mir_q        <= 1'b0;
      vblnk_prev_q <= 1'b0;
      s1_q         <= '0;
      rgb1_q       <= 12'h000;
      hit1_q       <= 1'b0;
      s2_q         <= '0;
      rgb2_q       <= 12'h000;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      en_q         <= en_d;
      mir_q        <= mir_d;
      vblnk_prev_q <= vblnk_prev_d;
      s1_q         <= s1_d;
      rgb1_q       <= rgb1_d;
      hit1_q       <= hit1_d;
      s2_q         <= s2_d;
      rgb2_q       <= rgb2_d;
    end
  end

  assign hcount_out = s2_q.hcount;
  assign hsync_out  = s2_q.hsync;
  assign hblnk_out  = s2_q.hblnk;
  assign vcount_out = s2_q.vcount;
  assign vsync_out  = s2_q.vsync;
  assign vblnk_out  = s2_q.vblnk;
  assign rgb_out    = rgb2_q;

endmodule

// File: tb/tb_draw_sprite.sv
// Randomised and directed bench for draw_sprite: two instances (scale 1x and 2x)
// share one stimulus stream and are compared against a frame-level reference model.
module tb_draw_sprite;

  localparam logic [11:0] KEY = 12'hF0F;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic        enable, mirror;

  logic [14:0] rom_addr0, rom_addr1;
  logic [11:0] rom_pixel0, rom_pixel1;
  logic [10:0] hc0, vc0, hc1, vc1;
  logic        hs0, hb0, vs0, vb0, hs1, hb1, vs1, vb1;
  logic [11:0] rgb_out0, rgb_out1;

  always #5 clk = ~clk;

  draw_sprite #(.SCALE_LOG2(0)) dut0 (
    .clk(clk), .reset(reset), .hcount_in(hcount_in), .hsync_in(hsync_in),
    .hblnk_in(hblnk_in), .vcount_in(vcount_in), .vsync_in(vsync_in),
    .vblnk_in(vblnk_in), .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .enable(enable), .mirror(mirror), .rom_addr(rom_addr0), .rom_pixel(rom_pixel0),
    .hcount_out(hc0), .hsync_out(hs0), .hblnk_out(hb0), .vcount_out(vc0),
    .vsync_out(vs0), .vblnk_out(vb0), .rgb_out(rgb_out0));

  draw_sprite #(.SCALE_LOG2(1)) dut1 (
    .clk(clk), .reset(reset), .hcount_in(hcount_in), .hsync_in(hsync_in),
    .hblnk_in(hblnk_in), .vcount_in(vcount_in), .vsync_in(vsync_in),
    .vblnk_in(vblnk_in), .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .enable(enable), .mirror(mirror), .rom_addr(rom_addr1), .rom_pixel(rom_pixel1),
    .hcount_out(hc1), .hsync_out(hs1), .hblnk_out(hb1), .vcount_out(vc1),
    .vsync_out(vs1), .vblnk_out(vb1), .rgb_out(rgb_out1));

  // Image ROM content: addr[11:0], with every 13th address holding the key colour.
  function automatic logic [11:0] rom_val(input int a);
    if (a % 13 == 0) return KEY;
    return a[11:0];
  endfunction

  always @(posedge clk) begin
    rom_pixel0 <= rom_val(int'(rom_addr0));
    rom_pixel1 <= rom_val(int'(rom_addr1));
  end

  typedef struct packed {
    logic [11:0] rgb0;
    logic [11:0] rgb1;
    logic [10:0] hc0; logic hs0; logic hb0; logic [10:0] vc0; logic vs0; logic vb0;
    logic [10:0] hc1; logic hs1; logic hb1; logic [10:0] vc1; logic vs1; logic vb1;
  } snap_t;

  int    vecs = 0;
  int    errs = 0;
  int    lx, ly;
  bit    len, lmir, lprev;
  snap_t expq[$];

  function automatic int ref_addr(input int h, input int v, input int x, input int y,
                                  input bit mir, input int sc, output bit inb);
    int w  = 328 << sc;
    int ht = 91 << sc;
    int rx;
    inb = (h >= x) && (h < x + w) && (v >= y) && (v < y + ht);
    if (!inb) return 0;
    rx = (h - x) >> sc;
    if (mir) rx = 327 - rx;
    return ((v - y) >> sc) * 328 + rx;
  endfunction

  task automatic reset_model();
    lx = 0; ly = 0; len = 1'b0; lmir = 1'b0; lprev = 1'b0;
    expq.delete();
    expq.push_back('0);
    expq.push_back('0);
  endtask

  // One pixel clock: snapshot outputs, drive inputs, model the result, advance.
  task automatic apply(input int h, input int v, input bit hs, input bit hb,
                       input bit vs, input bit vb, input int rgb, input int x,
                       input int y, input bit en, input bit mir,
                       output snap_t got, output snap_t want,
                       output int a0, output int a1, output int ea0, output int ea1);
    int          hh, vv, xx, yy;
    bit          ib0, ib1, blank;
    logic [10:0] hq, vq;
    logic [11:0] rq, r0, r1;
    snap_t       nx;
    got  = {rgb_out0, rgb_out1, hc0, hs0, hb0, vc0, vs0, vb0, hc1, hs1, hb1, vc1, vs1, vb1};
    want = expq.pop_front();
    hh = h & 2047; vv = v & 2047; xx = x & 4095; yy = y & 4095;
    hq = hh[10:0]; vq = vv[10:0]; rq = rgb[11:0];
    hcount_in = hq; vcount_in = vq; hsync_in = hs; hblnk_in = hb;
    vsync_in = vs; vblnk_in = vb; rgb_in = rq;
    xpos = xx[11:0]; ypos = yy[11:0]; enable = en; mirror = mir;
    #1;
    a0 = int'(rom_addr0);
    a1 = int'(rom_addr1);
    ea0 = ref_addr(hh, vv, lx, ly, lmir, 0, ib0);
    ea1 = ref_addr(hh, vv, lx, ly, lmir, 1, ib1);
    blank = hb || vb;
    r0 = rq; r1 = rq;
    if (blank) begin
      r0 = 12'h000; r1 = 12'h000;
    end else begin
      if (ib0 && len && rom_val(ea0) != KEY) r0 = rom_val(ea0);
      if (ib1 && len && rom_val(ea1) != KEY) r1 = rom_val(ea1);
    end
    nx = {r0, r1, hq, hs, hb, vq, vs, vb, hq, hs, hb, vq, vs, vb};
    expq.push_back(nx);
    if (vb && !lprev) begin
      lx = xx; ly = yy; len = en; lmir = mir;
    end
    lprev = vb;
    @(negedge clk);
  endtask

  task automatic test_reset();
    snap_t g, w;
    int a0, a1, e0, e1;
    reset = 1'b0;
    {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in} = '0;
    rgb_in = 12'h000; xpos = 12'h000; ypos = 12'h000; enable = 1'b0; mirror = 1'b0;
    repeat (3) @(negedge clk);
    reset_model();
    g = {rgb_out0, rgb_out1, hc0, hs0, hb0, vc0, vs0, vb0, hc1, hs1, hb1, vc1, vs1, vb1};
    vecs++;
    if (g !== '0) begin errs++; $display("FAIL reset_init got %h want 0", g); end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply(10 + i, 5, i[0], 1'b0, 1'b0, (i == 1), 12'h5A5 + i, 0, 0, 1'b1, 1'b0,
            g, w, a0, a1, e0, e1);
      vecs += 2;
      if (g !== w) begin errs++; $display("FAIL reset_run out got %h want %h", g, w); end
      if (a0 !== e0) begin errs++; $display("FAIL reset_run addr got %0d want %0d", a0, e0); end
    end
    // Asynchronous assertion in the middle of a cycle, away from any clock edge.
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    g = {rgb_out0, rgb_out1, hc0, hs0, hb0, vc0, vs0, vb0, hc1, hs1, hb1, vc1, vs1, vb1};
    vecs += 2;
    if (g !== '0) begin errs++; $display("FAIL reset_async out got %h want 0", g); end
    if ({rom_addr0, rom_addr1} !== 30'd0) begin
      errs++; $display("FAIL reset_async addr got %h want 0", {rom_addr0, rom_addr1});
    end
    @(negedge clk);
    reset_model();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply(700 + i, 400, 1'b1, 1'b0, 1'b1, 1'b0, 12'h123, 0, 0, 1'b0, 1'b0,
            g, w, a0, a1, e0, e1);
      vecs++;
      if (g !== w) begin errs++; $display("FAIL reset_release got %h want %h", g, w); end
    end
  endtask

  task automatic test_basic();
    snap_t g, w;
    int a0, a1, e0, e1;
    int hv[8] = '{105, 428, 427, 100, 99, 100, 100, 300};
    int vv[8] = '{203, 203, 203, 200, 200, 290, 291, 199};
    apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b0, 0, 100, 200, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
    apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b1, 0, 100, 200, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
    for (int i = 0; i < 8; i++) begin
      apply(hv[i], vv[i], 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC, 100, 200, 1'b1, 1'b0,
            g, w, a0, a1, e0, e1);
      vecs += 3;
      if (g !== w) begin errs++; $display("FAIL basic out got %h want %h", g, w); end
      if (a0 !== e0) begin errs++; $display("FAIL basic addr0 got %0d want %0d", a0, e0); end
      if (a1 !== e1) begin errs++; $display("FAIL basic addr1 got %0d want %0d", a1, e1); end
      if (i == 0) begin
        vecs++;
        if (a0 !== 989) begin errs++; $display("FAIL basic_989 got %0d want 989", a0); end
      end
    end
  endtask

  task automatic test_mirror();
    snap_t g, w;
    int a0, a1, e0, e1;
    apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b0, 0, 100, 200, 1'b1, 1'b1, g, w, a0, a1, e0, e1);
    apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b1, 0, 100, 200, 1'b1, 1'b1, g, w, a0, a1, e0, e1);
    for (int i = 0; i < 6; i++) begin
      apply(100 + i * 65, 203, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0, 100, 200, 1'b1, 1'b1,
            g, w, a0, a1, e0, e1);
      vecs += 2;
      if (g !== w) begin errs++; $display("FAIL mirror out got %h want %h", g, w); end
      if (a0 !== e0) begin errs++; $display("FAIL mirror addr got %0d want %0d", a0, e0); end
      if (i == 0) begin
        vecs++;
        if (a0 !== 1311) begin errs++; $display("FAIL mirror_1311 got %0d want 1311", a0); end
      end
    end
  endtask

  task automatic test_midframe();
    snap_t g, w;
    int a0, a1, e0, e1;
    apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b0, 0, 100, 200, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
    apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b1, 0, 100, 200, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
    for (int i = 0; i < 10; i++) begin
      if (i == 5)
        apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b0, 0, 300, 200, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
      if (i == 5)
        apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b1, 0, 300, 200, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
      apply((i % 5 == 1) ? 300 : 100 + (i % 5) * 80, 210, 1'b0, 1'b0, 1'b0, 1'b0,
            12'h777, 300, 200, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
      vecs += 2;
      if (g !== w) begin errs++; $display("FAIL midframe out got %h want %h", g, w); end
      if (a0 !== e0) begin errs++; $display("FAIL midframe addr got %0d want %0d", a0, e0); end
      if (i % 5 == 1) begin
        vecs++;
        if (a0 !== ((i < 5) ? 3480 : 3280)) begin
          errs++; $display("FAIL midframe_x got %0d want %0d", a0, (i < 5) ? 3480 : 3280);
        end
      end
    end
  endtask

  task automatic test_transparent_blank();
    snap_t g, w;
    int a0, a1, e0, e1;
    int  hv[5] = '{100, 113, 105, 105, 101};
    bit  hbv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bit  vbv[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b0, 0, 100, 200, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
    apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b1, 0, 100, 200, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
    apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b0, 0, 100, 200, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
    for (int i = 0; i < 7; i++) begin
      apply(hv[i % 5], (i < 5) ? 200 : 203, 1'b0, hbv[i % 5], 1'b0, vbv[i % 5],
            12'h3C3 + i, 100, 200, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
      vecs++;
      if (g !== w) begin errs++; $display("FAIL key_blank out got %h want %h", g, w); end
    end
  endtask

  task automatic test_scale();
    snap_t g, w;
    int a0, a1, e0, e1;
    int hv[7] = '{1000, 1001, 1023, 0, 1, 2, 1002};
    int ea[7] = '{0, 0, 11, 0, 0, 0, 1};
    apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1000, 50, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
    apply(0, 780, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1000, 50, 1'b1, 1'b0, g, w, a0, a1, e0, e1);
    for (int i = 0; i < 7; i++) begin
      apply(hv[i], 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246, 1000, 50, 1'b1, 1'b0,
            g, w, a0, a1, e0, e1);
      vecs += 2;
      if (g !== w) begin errs++; $display("FAIL scale out got %h want %h", g, w); end
      if (a1 !== ea[i]) begin errs++; $display("FAIL scale addr h=%0d got %0d want %0d", hv[i], a1, ea[i]); end
    end
  endtask

  task automatic test_random();
    snap_t g, w;
    int a0, a1, e0, e1;
    int h, v, x, y;
    for (int i = 0; i < 1500; i++) begin
      x = $urandom_range(0, 1200);
      y = $urandom_range(0, 800);
      if ($urandom_range(0, 3) != 0) begin
        h = lx + $urandom_range(0, 700);
        v = ly + $urandom_range(0, 400);
      end else begin
        h = $urandom_range(0, 2047);
        v = $urandom_range(0, 2047);
      end
      apply(h, v, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
            $urandom_range(0, 4095), x, y, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, g, w, a0, a1, e0, e1);
      vecs += 3;
      if (g !== w) begin errs++; $display("FAIL random[%0d] out got %h want %h", i, g, w); end
      if (a0 !== e0) begin errs++; $display("FAIL random[%0d] addr0 got %0d want %0d", i, a0, e0); end
      if (a1 !== e1) begin errs++; $display("FAIL random[%0d] addr1 got %0d want %0d", i, a1, e1); end
    end
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, g, w, a0, a1, e0, e1);
      vecs++;
      if (g !== w) begin errs++; $display("FAIL drain got %h want %h", g, w); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mirror();
    test_midframe();
    test_transparent_blank();
    test_scale();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
